// File: rtl/fuzz_stream_pkg.sv
// Shared definitions for the fuzz-harness stream packers.
// Contents:
//   DEF_BYTE_W / DEF_CNT_W  default stream-word and counter widths
//   calc_nbytes()           stream words needed to cover a flat vector
//   pack_state_e            packer phase: FILL (collecting) / LOAD (next byte completes a vector)
package fuzz_stream_pkg;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_CNT_W  = 16;

  function automatic int calc_nbytes(input int flat_w, input int byte_w);
    return (flat_w + byte_w - 1) / byte_w;
  endfunction

  typedef enum logic {
    FILL = 1'b0,
    LOAD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/flat_vector_packer_if.sv
// Byte-stream in / flat-vector out bundle for flat_vector_packer.
//   master : fuzz driver / consumer side (drives bytes and vec_ready)
//   slave  : the packer
// Signals:
//   byte_in, byte_valid, byte_ready   input byte stream handshake
//   vec_out, vec_valid, vec_ready     assembled vector handshake
//   vec_count                         vectors handed off (saturating)
interface flat_vector_packer_if #(
  parameter int BYTE_W = 8,
  parameter int FLAT_W = 12,
  parameter int CNT_W  = 16
);
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [FLAT_W-1:0] vec_out;
  logic              vec_valid;
  logic              vec_ready;
  logic [CNT_W-1:0]  vec_count;

  modport master (
    output byte_in, byte_valid, vec_ready,
    input  byte_ready, vec_out, vec_valid, vec_count
  );

  modport slave (
    input  byte_in, byte_valid, vec_ready,
    output byte_ready, vec_out, vec_valid, vec_count
  );
endinterface

// File: rtl/vec_out_reg.sv
// Single-entry valid/ready output register.
// A new word may load in the same cycle the current one drains, so a
// producer that watches 'free' sustains one word per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load, din  write din into the slot (only when free=1)
//   ready      consumer accepts dout this cycle
//   dout/valid registered output word and its valid
//   free       slot empty or draining this cycle
module vec_out_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flat_vector_packer.sv
// Packs an MSB-first byte stream into FLAT_W-bit vectors for a flattened
// wrapper's in_flat port.  b0 lands in the most significant position; the
// unused low bits of the final byte are dropped.
// Optional feature: PAD_FLUSH_EN adds a 'flush' input that emits a partial
// vector zero-padded in the low bytes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      (PAD_FLUSH_EN only) emit the partial vector now
//   bus        flat_vector_packer_if.slave: byte stream in, vector out, count
module flat_vector_packer
  import fuzz_stream_pkg::*;
#(
  parameter int FLAT_W = 12,
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
`ifdef PAD_FLUSH_EN
  input  logic flush,
`endif
  flat_vector_packer_if.slave bus
);

  localparam int NBYTES = calc_nbytes(FLAT_W, BYTE_W);
  localparam int WORD_W = NBYTES * BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W:0]   NB_CNT   = (IDX_W+1)'(NBYTES);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  pack_state_e       phase;

  logic              slot_free;
  logic              byte_ready, byte_xfer;
  logic              load, load_full, flush_emit;
  logic [WORD_W-1:0] acc_in, word;
  logic [IDX_W:0]    held, pad_cnt;
  logic [FLAT_W-1:0] vec_d, vec_q;
  logic              vec_valid;
  logic [CNT_W-1:0]  cnt_q;

  // State register: byte index and shift accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // Output / datapath comb: handshake and the word to load.
  always_comb begin
    phase      = (idx_q == LAST_IDX) ? LOAD : FILL;
    byte_ready = !rst && (phase == FILL || slot_free);
    byte_xfer  = bus.byte_valid && byte_ready;
    acc_in     = byte_xfer ? ((acc_q << BYTE_W) | WORD_W'(bus.byte_in)) : acc_q;
    held       = {1'b0, idx_q} + (IDX_W+1)'(byte_xfer);
    load_full  = byte_xfer && (phase == LOAD);
`ifdef PAD_FLUSH_EN
    // Only a non-empty partial vector can be flushed, and only into a free slot.
    flush_emit = flush && (idx_q != '0) && slot_free;
`else
    flush_emit = 1'b0;
`endif
    load       = load_full || flush_emit;
    // Bytes still missing become zero padding below the received ones.
    pad_cnt    = NB_CNT - held;
    word       = acc_in << (int'(pad_cnt) * BYTE_W);
    vec_d      = FLAT_W'(word >> (WORD_W - FLAT_W));
  end

  // Next-state comb.
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (load) begin
      idx_d = '0;
      acc_d = '0;
    end else if (byte_xfer) begin
      idx_d = idx_q + IDX_W'(1);
      acc_d = acc_in;
    end
  end

  vec_out_reg #(.W(FLAT_W)) u_vec_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (vec_d),
    .ready (bus.vec_ready),
    .dout  (vec_q),
    .valid (vec_valid),
    .free  (slot_free)
  );

  // Handoff counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (vec_valid && bus.vec_ready && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.byte_ready = byte_ready;
  assign bus.vec_out    = vec_q;
  assign bus.vec_valid  = vec_valid;
  assign bus.vec_count  = cnt_q;

endmodule

// File: tb/tb_flat_vector_packer.sv
module tb_flat_vector_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flat_vector_packer_if #(.BYTE_W(8), .FLAT_W(12), .CNT_W(16)) ifa ();
  flat_vector_packer_if #(.BYTE_W(8), .FLAT_W(12), .CNT_W(4))  ifb ();

`ifdef PAD_FLUSH_EN
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;
`endif

  flat_vector_packer #(.FLAT_W(12), .BYTE_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
`ifdef PAD_FLUSH_EN
    .flush(flush_a),
`endif
    .bus(ifa.slave)
  );

  flat_vector_packer #(.FLAT_W(12), .BYTE_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
`ifdef PAD_FLUSH_EN
    .flush(flush_b),
`endif
    .bus(ifb.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int nb_b = 0;

  logic [7:0]  in_q[$];
  logic [11:0] out_q[$];
  int          out_cyc[$];

  // Observation only: record every handshake on DUT a, count handoffs on b.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (ifa.byte_valid && ifa.byte_ready) in_q.push_back(ifa.byte_in);
      if (ifa.vec_valid && ifa.vec_ready) begin
        out_q.push_back(ifa.vec_out);
        out_cyc.push_back(cyc);
      end
      if (ifb.vec_valid && ifb.vec_ready) nb_b <= nb_b + 1;
    end
  end

  // Reference: two bytes form a 16-bit big-endian number; the vector is its
  // top 12 bits.
  function automatic logic [11:0] ref_vec(input logic [7:0] b0, input logic [7:0] b1);
    int w;
    w = int'(b0) * 256 + int'(b1);
    return 12'(w / 16);
  endfunction

  task automatic clear_obs();
    in_q.delete();
    out_q.delete();
    out_cyc.delete();
  endtask

  // Drives one byte and waits for it to be taken; ok=0 on timeout.
  task automatic push_a(input logic [7:0] b, output bit ok);
    ifa.byte_in = b;
    ifa.byte_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (ifa.byte_ready) ok = 1'b1;
      #1;
      if (ok) break;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.byte_valid = 1'b1; ifa.byte_in = 8'h55; ifa.vec_ready = 1'b0;
    ifb.byte_valid = 1'b0; ifb.byte_in = 8'h00; ifb.vec_ready = 1'b0;
    idle_cycles(2);
    n_total++; if (ifa.byte_ready !== 1'b0) $display("FAIL reset_byte_ready: got %b want 0", ifa.byte_ready); else n_pass++;
    n_total++; if (ifa.vec_valid !== 1'b0) $display("FAIL reset_vec_valid: got %b want 0", ifa.vec_valid); else n_pass++;
    n_total++; if (ifa.vec_out !== 12'h000) $display("FAIL reset_vec_out: got %h want 000", ifa.vec_out); else n_pass++;
    n_total++; if (ifa.vec_count !== 16'd0) $display("FAIL reset_vec_count: got %0d want 0", ifa.vec_count); else n_pass++;
    n_total++; if (ifb.vec_count !== 4'd0) $display("FAIL reset_vec_count_b: got %0d want 0", ifb.vec_count); else n_pass++;
    ifa.byte_valid = 1'b0;
    rst = 1'b0;
    idle_cycles(1);
    clear_obs();
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    bit ok0, ok1;
    ifa.vec_ready = 1'b1;
    push_a(8'hA5, ok0);
    push_a(8'h3C, ok1);
    ifa.byte_valid = 1'b0;
    n_total++; if (!(ok0 && ok1)) $display("FAIL basic_accept: got %b%b want 11", ok0, ok1); else n_pass++;
    n_total++; if (ifa.vec_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", ifa.vec_valid); else n_pass++;
    n_total++; if (ifa.vec_out !== 12'hA53) $display("FAIL basic_vec_out: got %h want a53", ifa.vec_out); else n_pass++;
    idle_cycles(1);
    exp_cnt += 1;
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL basic_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    n_total++; if (ifa.vec_valid !== 1'b0) $display("FAIL basic_valid_clear: got %b want 0", ifa.vec_valid); else n_pass++;
    clear_obs();
  endtask

  task automatic test_backpressure();
    bit ok;
    ifa.vec_ready = 1'b0;
    push_a(8'h12, ok);
    push_a(8'h34, ok);
    push_a(8'h56, ok);
    n_total++; if (!ok) $display("FAIL bp_accept_56: got 0 want 1"); else n_pass++;
    ifa.byte_in = 8'h78;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      n_total++; if (ifa.byte_ready !== 1'b0) $display("FAIL bp_byte_ready c%0d: got %b want 0", c, ifa.byte_ready); else n_pass++;
      #1;
      n_total++; if (ifa.vec_out !== 12'h123 || ifa.vec_valid !== 1'b1)
        $display("FAIL bp_hold c%0d: got %h/%b want 123/1", c, ifa.vec_out, ifa.vec_valid); else n_pass++;
    end
    ifa.vec_ready = 1'b1;
    @(posedge clk);
    n_total++; if (ifa.byte_ready !== 1'b1) $display("FAIL bp_overlap_ready: got %b want 1", ifa.byte_ready); else n_pass++;
    #1;
    ifa.byte_valid = 1'b0;
    n_total++; if (ifa.vec_out !== 12'h567 || ifa.vec_valid !== 1'b1)
      $display("FAIL bp_second_vec: got %h/%b want 567/1", ifa.vec_out, ifa.vec_valid); else n_pass++;
    idle_cycles(2);
    n_total++; if (in_q.size() != 4 || out_q.size() != 2)
      $display("FAIL bp_counts: got %0d bytes %0d vecs want 4 2", in_q.size(), out_q.size()); else n_pass++;
    for (int i = 0; i < out_q.size() && 2*i+1 < in_q.size(); i++) begin
      n_total++; if (out_q[i] !== ref_vec(in_q[2*i], in_q[2*i+1]))
        $display("FAIL bp_vec%0d: got %h want %h", i, out_q[i], ref_vec(in_q[2*i], in_q[2*i+1])); else n_pass++;
    end
    exp_cnt += out_q.size();
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL bp_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    clear_obs();
  endtask

  task automatic test_throughput();
    bit ok;
    int t0, slow;
    slow = 0;
    ifa.vec_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      push_a(8'($urandom), ok);
      if (!ok) slow++;
    end
    n_total++; if (cyc - t0 != 20 || slow != 0)
      $display("FAIL tp_cycles: got %0d cycles want 20", cyc - t0); else n_pass++;
    ifa.byte_valid = 1'b0;
    idle_cycles(2);
    n_total++; if (out_q.size() != 10) $display("FAIL tp_nvec: got %0d want 10", out_q.size()); else n_pass++;
    for (int i = 0; i < out_q.size() && 2*i+1 < in_q.size(); i++) begin
      n_total++; if (out_q[i] !== ref_vec(in_q[2*i], in_q[2*i+1]))
        $display("FAIL tp_vec%0d: got %h want %h", i, out_q[i], ref_vec(in_q[2*i], in_q[2*i+1])); else n_pass++;
    end
    for (int i = 1; i < out_cyc.size(); i++) begin
      n_total++; if (out_cyc[i] - out_cyc[i-1] != 2)
        $display("FAIL tp_spacing%0d: got %0d want 2", i, out_cyc[i] - out_cyc[i-1]); else n_pass++;
    end
    exp_cnt += 10;
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL tp_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    clear_obs();
  endtask

  task automatic test_reset_midfill();
    bit ok;
    ifa.vec_ready = 1'b1;
    push_a(8'hFF, ok);
    ifa.byte_valid = 1'b0;
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    clear_obs();
    exp_cnt = 0;
    push_a(8'h01, ok);
    push_a(8'h20, ok);
    ifa.byte_valid = 1'b0;
    n_total++; if (ifa.vec_out !== 12'h012) $display("FAIL rmf_vec_out: got %h want 012", ifa.vec_out); else n_pass++;
    idle_cycles(2);
    n_total++; if (out_q.size() != 1) $display("FAIL rmf_nvec: got %0d want 1", out_q.size()); else n_pass++;
    exp_cnt = 1;
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL rmf_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    clear_obs();
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] prev_out;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < 300; c++) begin
      ifa.byte_valid = ($urandom_range(0, 3) != 0);
      ifa.byte_in = 8'($urandom);
      ifa.vec_ready = $urandom_range(0, 1) != 0;
      prev_stall = ifa.vec_valid && !ifa.vec_ready;
      prev_out = ifa.vec_out;
      @(posedge clk); #1;
      if (prev_stall) begin
        n_total++; if (ifa.vec_valid !== 1'b1 || ifa.vec_out !== prev_out)
          $display("FAIL rnd_stable c%0d: got %h/%b want %h/1", c, ifa.vec_out, ifa.vec_valid, prev_out); else n_pass++;
      end
    end
    ifa.byte_valid = 1'b0;
    ifa.vec_ready = 1'b1;
    if (in_q.size() % 2 != 0) push_a(8'($urandom), ok);
    ifa.byte_valid = 1'b0;
    idle_cycles(3);
    n_total++; if (out_q.size() != in_q.size() / 2)
      $display("FAIL rnd_nvec: got %0d want %0d", out_q.size(), in_q.size() / 2); else n_pass++;
    for (int i = 0; i < out_q.size() && 2*i+1 < in_q.size(); i++) begin
      n_total++; if (out_q[i] !== ref_vec(in_q[2*i], in_q[2*i+1]))
        $display("FAIL rnd_vec%0d: got %h want %h", i, out_q[i], ref_vec(in_q[2*i], in_q[2*i+1])); else n_pass++;
    end
    exp_cnt += out_q.size();
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL rnd_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    clear_obs();
  endtask

  task automatic test_saturation();
    int n0;
    n0 = nb_b;
    ifb.vec_ready = 1'b1;
    ifb.byte_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ifb.byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    ifb.byte_valid = 1'b0;
    idle_cycles(3);
    n_total++; if (nb_b - n0 != 20) $display("FAIL sat_nvec: got %0d want 20", nb_b - n0); else n_pass++;
    n_total++; if (ifb.vec_count !== 4'd15) $display("FAIL sat_count: got %0d want 15", ifb.vec_count); else n_pass++;
  endtask

`ifdef PAD_FLUSH_EN
  task automatic test_flush();
    bit ok;
    ifa.vec_ready = 1'b0;
    flush_a = 1'b1;
    idle_cycles(1);
    flush_a = 1'b0;
    n_total++; if (ifa.vec_valid !== 1'b0) $display("FAIL flush_idle: got %b want 0", ifa.vec_valid); else n_pass++;
    push_a(8'hBE, ok);
    ifa.byte_valid = 1'b0;
    flush_a = 1'b1;
    idle_cycles(1);
    flush_a = 1'b0;
    n_total++; if (ifa.vec_valid !== 1'b1 || ifa.vec_out !== 12'hBE0)
      $display("FAIL flush_emit: got %h/%b want be0/1", ifa.vec_out, ifa.vec_valid); else n_pass++;
    ifa.vec_ready = 1'b1;
    push_a(8'h11, ok);
    push_a(8'h22, ok);
    ifa.byte_valid = 1'b0;
    idle_cycles(2);
    n_total++; if (out_q.size() != 2) $display("FAIL flush_nvec: got %0d want 2", out_q.size()); else n_pass++;
    if (out_q.size() == 2) begin
      n_total++; if (out_q[0] !== 12'hBE0 || out_q[1] !== 12'h112)
        $display("FAIL flush_seq: got %h %h want be0 112", out_q[0], out_q[1]); else n_pass++;
    end
    exp_cnt += out_q.size();
    n_total++; if (ifa.vec_count !== 16'(exp_cnt)) $display("FAIL flush_count: got %0d want %0d", ifa.vec_count, exp_cnt); else n_pass++;
    clear_obs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_throughput();
    test_reset_midfill();
    test_random();
    test_saturation();
`ifdef PAD_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
